pipe_stage_buf: RTL
===================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the payload width in bits ({pc,inst} for a decode/execute stage).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of buffer entries; legal values are powers of two, 2 to 8.
REQ-003 The block SHALL have parameter FLUSH_NOP, default 0, giving the payload presented on out_data when the buffer is empty.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-low.
REQ-006 Port in_valid  input  1  upstream offers in_data.
REQ-007 Port in_ready  output  1  buffer can accept one entry this cycle.
REQ-008 Port in_data  input  DATA_W  upstream payload.
REQ-009 Port ready_go  input  1  stage work on the head entry is complete.
REQ-010 Port out_valid  output  1  head entry is offered downstream.
REQ-011 Port out_ready  input  1  downstream accepts the head entry.
REQ-012 Port out_data  output  DATA_W  head entry payload.
REQ-013 Port flush  input  1  branch/exception kill; discards all held and incoming entries.
REQ-014 Port count  output  $clog2(DEPTH+1)  number of occupied entries.
REQ-015 Port empty  output  1  count==0.
REQ-016 Port full  output  1  count==DEPTH.

Function
REQ-017 The block SHALL behave as a circular FIFO with a write pointer and a read pointer, each $clog2(DEPTH) bits wide, each wrapping from DEPTH-1 to 0.
REQ-018 in_ready SHALL equal !full && rst, and SHALL have no combinational path from out_ready, ready_go or flush.
REQ-019 A push SHALL occur when in_valid && in_ready && !flush; the entry is written at wr_ptr and wr_ptr increments.
REQ-020 out_valid SHALL equal !empty && ready_go.
REQ-021 A pop SHALL occur when out_valid && out_ready; rd_ptr increments.
REQ-022 out_data SHALL show the entry at rd_ptr when !empty, and FLUSH_NOP when empty.
REQ-023 Latency SHALL be one cycle: an entry pushed at edge N is visible on out_data and out_valid (given ready_go) after edge N.
REQ-024 When push and pop occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-025 When full, the block SHALL accept no push even if a pop occurs that cycle (no bypass); DEPTH>=2 sustains one transfer per cycle.
REQ-026 When flush is high at an edge, count, wr_ptr and rd_ptr SHALL become 0 and the concurrent push SHALL be dropped.
REQ-027 When flush is high at an edge, a concurrent pop handshake SHALL count as delivered downstream; the consumer handles the kill of that entry.
REQ-028 While ready_go is low, out_valid SHALL be 0 and the entries and pointers SHALL be held; pushes SHALL continue until full.
REQ-029 Entry storage SHALL not be reset; only the pointers and count are reset.

Reset
REQ-030 When rst==0 at an edge, count, wr_ptr and rd_ptr SHALL become 0.
REQ-031 While rst==0, out_valid SHALL be 0, in_ready SHALL be 0, empty SHALL be 1, full SHALL be 0 and out_data SHALL equal FLUSH_NOP.
REQ-032 Reset asserted mid-operation SHALL discard all entries at the next edge; the first push is accepted in the first cycle with rst==1.
REQ-033 Reset SHALL take priority over flush, push and pop.

Structure
REQ-034 A shared package pipe_pkg SHALL hold the default widths PC_W=32 and INST_W=32, the derived PAYLOAD_W and the NOP encoding constant; the block SHALL import them as parameter defaults.
REQ-035 The block SHALL be a single module with no sub-modules; storage is an inline register array and the count is an inline counter.

Verification
REQ-036 Streaming: DEPTH=2, ready_go=1, out_ready=1, push 0x1C000000_02800000 to 0x1C00000C_0280000C over 4 cycles -> the same 4 values exit in order, each one cycle after its push, with in_ready constantly 1.
REQ-037 Backpressure: out_ready=0 and push 3 entries -> full=1 and in_ready=0 after 2 pushes, count=2, the third entry is held upstream; release out_ready -> entries exit in order and the third entry is then accepted.
REQ-038 Flush: count=2 and flush=1 together with in_valid=1 -> count=0, empty=1, out_data=FLUSH_NOP next cycle, and the incoming entry never appears.
REQ-039 ready_go stall: one entry held, ready_go=0 for 3 cycles -> out_valid=0 throughout with the entry retained; ready_go=1 -> out_valid=1 with the same out_data.
REQ-040 Reset mid-stream: count=1, rst=0 for 1 cycle -> count=0 and in_ready=0 during reset; the push in the next cycle is accepted and exits after 1 cycle.
REQ-041 Wrap: DEPTH=4, push and pop 9 entries with a random out_ready pattern -> order is preserved across pointer wrap and count never exceeds 4.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline widths and encodings.
// Imported by stage buffers for their parameter defaults.
package pipe_pkg;

    localparam int PC_W      = 32;
    localparam int INST_W    = 32;
    localparam int PAYLOAD_W = PC_W + INST_W;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0;

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic buffer between pipeline stages.
// Circular FIFO with flush, stage-done gating and an empty-slot payload.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = PAYLOAD_W,
    parameter int                DEPTH     = 2,
    parameter logic [DATA_W-1:0] FLUSH_NOP = NOP_PAYLOAD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       ready_go,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Occupancy flags, masked so reset looks like an empty buffer.
    always_comb begin
        empty     = !rst || (count == '0);
        full      = rst && (count == FULL_CNT);
        in_ready  = !full && rst;
        out_valid = !empty && ready_go;
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready;
        out_data  = empty ? FLUSH_NOP : mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping; reset beats flush beats traffic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE_PTR;
            if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
            unique case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    // Payload storage holds no reset; only accepted pushes write it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule
